// File: rtl/alu_pkg.sv
// Shared ALU definitions: encodings, checker states and golden model.
// The model works at a fixed maximum width; callers pass their width n.
package alu_pkg;

  localparam int MAX_W = 32;

  localparam logic [1:0] OP_TRANSFER = 2'b00;
  localparam logic [1:0] OP_ADD      = 2'b01;
  localparam logic [1:0] OP_SUB      = 2'b10;
  localparam logic [1:0] OP_RSUB     = 2'b11;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

  localparam logic MODE_ARITH = 1'b1;
  localparam logic MODE_LOGIC = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } chk_state_e;

  // a and b must be zero above bit n-1; result bit n is carry/borrow.
  function automatic logic [MAX_W:0] alu_model(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input logic             cin,
    input logic [1:0]       oper,
    input logic             mode,
    input int               n
  );
    logic [MAX_W:0] ea;
    logic [MAX_W:0] eb;
    logic [MAX_W:0] ec;
    logic [MAX_W:0] r;
    logic [MAX_W:0] m_res;
    logic [MAX_W:0] m_log;
    ea = {1'b0, a};
    eb = {1'b0, b};
    ec = {{MAX_W{1'b0}}, cin};
    for (int i = 0; i <= MAX_W; i++) begin
      m_res[i] = (i <= n);
      m_log[i] = (i < n);
    end
    if (mode == MODE_ARITH) begin
      unique case (oper)
        OP_TRANSFER: r = ea;
        OP_ADD:      r = ea + eb + ec;
        OP_SUB:      r = ea - eb - ec;
        default:     r = eb - ea - ec;
      endcase
      r = r & m_res;
    end else begin
      unique case (oper)
        OP_AND:  r = ea & eb;
        OP_OR:   r = ea | eb;
        OP_XOR:  r = ea ^ eb;
        default: r = ~(ea ^ eb);
      endcase
      r = r & m_log;
    end
    return r;
  endfunction

endpackage

// File: rtl/exp_fifo.sv
// Expectation FIFO: synchronous, wrap-around pointers with an extra MSB.
// Push while full is accepted only together with a pop.
module exp_fifo
  import alu_pkg::*;
#(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic         wr_en;
  logic         rd_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
               & (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  assign wr_en = push & (~full | pop);
  assign rd_en = pop & ~empty;

  // Pointer advance; clear empties the queue.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_result_checker.sv
// In-order ALU response checker: queues golden results per request
// and compares them against returned results, with sticky error flags.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int N       = 4,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             req_valid,
  input  logic [N-1:0]     A,
  input  logic [N-1:0]     B,
  input  logic             Cin,
  input  logic [1:0]       Oper,
  input  logic             Mode,
  input  logic             res_valid,
  input  logic [N-1:0]     Sum,
  input  logic             Cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             overflow,
  output logic             underflow,
  output logic             timeout,
  output logic [N:0]       err_exp,
  output logic [N:0]       err_got,
  output logic             err_valid
);

  localparam int DW = $clog2(TIMEOUT + 1);

  chk_state_e       state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             tmo_q, tmo_d;
  logic [N:0]       err_exp_q, err_exp_d;
  logic [N:0]       err_got_q, err_got_d;
  logic             err_vld_q, err_vld_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [MAX_W:0]       exp_full;
  logic [MAX_W-N-1:0]   unused_exp_hi;
  logic [N:0]           exp_val;
  logic [N:0]           fifo_rdata;
  logic [N:0]           cmp_exp;
  logic [N:0]           got;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push_req;
  logic                 pop_req;
  logic                 bypass;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 cmp_en;
  logic                 match;

  assign exp_full = alu_model({{(MAX_W-N){1'b0}}, A},
                              {{(MAX_W-N){1'b0}}, B},
                              Cin, Oper, Mode, N);
  assign exp_val       = exp_full[N:0];
  assign unused_exp_hi = exp_full[MAX_W:N+1];

  // Handshake decode: start takes priority over any traffic.
  always_comb begin
    push_req  = (state_q == ST_RUN) & req_valid & ~start;
    pop_req   = ((state_q == ST_RUN) | (state_q == ST_DRAIN))
              & res_valid & ~start;
    bypass    = push_req & pop_req & fifo_empty;
    fifo_push = push_req & ~bypass;
    fifo_pop  = pop_req & ~fifo_empty;
    cmp_en    = fifo_pop | bypass;
    cmp_exp   = fifo_empty ? exp_val : fifo_rdata;
    got       = {Cout, Sum};
    match     = (cmp_exp == got);
  end

  exp_fifo #(
    .W     (N + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst   (rst),
    .clr   (start),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (exp_val),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state, counters, flags and first-mismatch capture.
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    tmo_d      = tmo_q;
    err_exp_d  = err_exp_q;
    err_got_d  = err_got_q;
    err_vld_d  = err_vld_q;
    if (start) begin
      state_d    = ST_RUN;
      drain_d    = '0;
      pass_cnt_d = '0;
      fail_cnt_d = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      tmo_d      = 1'b0;
      err_exp_d  = '0;
      err_got_d  = '0;
      err_vld_d  = 1'b0;
    end else begin
      if (cmp_en && match) begin
        if (pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + 1'b1;
      end
      if (cmp_en && !match) begin
        if (fail_cnt_q != '1) fail_cnt_d = fail_cnt_q + 1'b1;
        if (!err_vld_q) begin
          err_exp_d = cmp_exp;
          err_got_d = got;
          err_vld_d = 1'b1;
        end
      end
      if (push_req && fifo_full && !pop_req) ovf_d = 1'b1;
      if (pop_req && fifo_empty && !push_req) unf_d = 1'b1;
      unique case (state_q)
        ST_RUN: begin
          if (stop) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end
        end
        ST_DRAIN: begin
          if (fifo_empty) begin
            state_d = ST_DONE;
          end else if (drain_q == DW'(TIMEOUT)) begin
            state_d = ST_DONE;
            tmo_d   = 1'b1;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == ST_RUN) | (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      drain_q    <= '0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      err_exp_q  <= '0;
      err_got_q  <= '0;
      err_vld_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      tmo_q      <= tmo_d;
      err_exp_q  <= err_exp_d;
      err_got_q  <= err_got_d;
      err_vld_q  <= err_vld_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass_cnt  = pass_cnt_q;
  assign fail_cnt  = fail_cnt_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign timeout   = tmo_q;
  assign err_exp   = err_exp_q;
  assign err_got   = err_got_q;
  assign err_valid = err_vld_q;
  assign pass      = done_q & (fail_cnt_q == '0) & ~ovf_q & ~unf_q
                   & ~tmo_q & (pass_cnt_q != '0);

endmodule
